// File: rtl/reorder_buffer_pkg.sv
// Shared CPU constants for the reorder buffer: sizing defaults, instruction-type
// encodings, the per-entry record and instruction-class helpers.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH   = 16;
    localparam int ROB_TAG_W   = 4;
    localparam int INST_TYPE_W = 4;

    typedef enum logic [INST_TYPE_W-1:0] {
        INST_ALU  = 4'd0,
        INST_LOAD = 4'd1,
        INST_JAL  = 4'd2,
        INST_JALR = 4'd3,
        INST_BEQ  = 4'd4,
        INST_BNE  = 4'd5,
        INST_BLT  = 4'd6,
        INST_BGE  = 4'd7,
        INST_BLTU = 4'd8,
        INST_BGEU = 4'd9,
        INST_SB   = 4'd10,
        INST_SH   = 4'd11,
        INST_SW   = 4'd12
    } inst_type_e;

    typedef struct packed {
        inst_type_e  inst_type;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] target;
        logic [31:0] value;
        logic [31:0] jumppc;
    } rob_entry_t;

    function automatic logic is_store(input inst_type_e t);
        return t inside {INST_SB, INST_SH, INST_SW};
    endfunction

    function automatic logic is_cond_branch(input inst_type_e t);
        return t inside {INST_BEQ, INST_BNE, INST_BLT, INST_BGE, INST_BLTU, INST_BGEU};
    endfunction

endpackage

// File: rtl/rob_branch_resolve.sv
// Combinational misprediction check and redirect target for the entry being
// committed at the head of the reorder buffer.
module rob_branch_resolve
    import reorder_buffer_pkg::*;
(
    input  inst_type_e  inst_type,
    input  logic [31:0] pc,
    input  logic        pred_taken,
    input  logic [31:0] target,
    input  logic [31:0] value,
    input  logic [31:0] jumppc,
    output logic        mispredict,
    output logic [31:0] redirect_pc
);

    logic actual_taken;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        actual_taken = 1'b0;
        mispredict   = 1'b0;
        redirect_pc  = pc + 32'd4;
        if (is_cond_branch(inst_type)) begin
            actual_taken = value[0];
            mispredict   = (actual_taken != pred_taken);
            redirect_pc  = actual_taken ? target : pc + 32'd4;
        end else if (inst_type == INST_JALR) begin
            mispredict  = (jumppc != target);
            redirect_pc = jumppc;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, collects RS/SLB writebacks,
// commits the head and flushes on a mispredict. Option: ROB_COMMIT_BYPASS_EN.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    output logic [TAG_W-1:0]       alloc_tag,
    input  logic [INST_TYPE_W-1:0] alloc_type,
    input  logic [4:0]             alloc_rd,
    input  logic [31:0]            alloc_pc,
    input  logic                   alloc_pred_taken,
    input  logic [31:0]            alloc_target,
    input  logic                   rs_wb_valid,
    input  logic [TAG_W-1:0]       rs_wb_tag,
    input  logic [31:0]            rs_wb_value,
    input  logic                   rs_wb_jumppc_valid,
    input  logic [31:0]            rs_wb_jumppc,
    input  logic                   slb_wb_valid,
    input  logic [TAG_W-1:0]       slb_wb_tag,
    input  logic [31:0]            slb_wb_value,
    output logic                   commit_valid,
    output logic [TAG_W-1:0]       commit_tag,
    output logic [4:0]             commit_rd,
    output logic [31:0]            commit_value,
    output logic                   store_commit,
    output logic                   clear_flag,
    output logic [31:0]            redirect_pc
);

    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count;
    logic [DEPTH-1:0] busy, ready;
    rob_entry_t       entries [DEPTH];

    rob_entry_t  head_entry;
    logic [31:0] head_value, head_jumppc;
    logic        head_ready;
    logic        do_alloc, do_commit, rs_hit, slb_hit;
    logic        mispredict;
    logic [31:0] resolved_pc;

    always_comb begin
        alloc_ready = !rst && rdy && !clear_flag && (count != (TAG_W+1)'(DEPTH));
        alloc_tag   = tail;
        do_alloc    = alloc_valid && alloc_ready;
        rs_hit      = !rst && rdy && !clear_flag && rs_wb_valid && busy[rs_wb_tag];
        slb_hit     = !rst && rdy && !clear_flag && slb_wb_valid && busy[slb_wb_tag];
        head_entry  = entries[head];
        head_value  = head_entry.value;
        head_jumppc = head_entry.jumppc;
        head_ready  = ready[head];
`ifdef ROB_COMMIT_BYPASS_EN
        // A writeback landing on the head is forwarded straight into this commit.
        if (rs_hit && rs_wb_tag == head) begin
            head_ready = 1'b1;
            head_value = rs_wb_value;
            if (rs_wb_jumppc_valid) head_jumppc = rs_wb_jumppc;
        end else if (slb_hit && slb_wb_tag == head) begin
            head_ready = 1'b1;
            head_value = slb_wb_value;
        end
`endif
        do_commit = !rst && rdy && !clear_flag && busy[head] && head_ready;
    end

    rob_branch_resolve u_resolve (
        .inst_type  (head_entry.inst_type),
        .pc         (head_entry.pc),
        .pred_taken (head_entry.pred_taken),
        .target     (head_entry.target),
        .value      (head_value),
        .jumppc     (head_jumppc),
        .mispredict (mispredict),
        .redirect_pc(resolved_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            commit_valid <= 1'b0;
            commit_tag   <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            store_commit <= 1'b0;
            clear_flag   <= 1'b0;
            redirect_pc  <= '0;
        end else if (clear_flag) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
            clear_flag   <= 1'b0;
        end else if (rdy) begin
            commit_valid <= do_commit;
            store_commit <= do_commit && is_store(head_entry.inst_type);
            clear_flag   <= do_commit && mispredict;
            if (do_commit) begin
                commit_tag   <= head;
                commit_rd    <= (is_store(head_entry.inst_type) || is_cond_branch(head_entry.inst_type))
                                ? 5'd0 : head_entry.rd;
                commit_value <= head_value;
                redirect_pc  <= resolved_pc;
                busy[head]   <= 1'b0;
                head         <= head + TAG_W'(1);
            end
            if (do_alloc) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + TAG_W'(1);
            end
            if (slb_hit) ready[slb_wb_tag] <= 1'b1;
            if (rs_hit)  ready[rs_wb_tag]  <= 1'b1;
            count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
        end else begin
            commit_valid <= 1'b0;
            store_commit <= 1'b0;
            clear_flag   <= 1'b0;
        end
    end

    // NOTE: the payload array has no reset; busy/ready decide whether an entry means anything.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            entries[tail] <= '{inst_type:  inst_type_e'(alloc_type),
                               rd:         alloc_rd,
                               pc:         alloc_pc,
                               pred_taken: alloc_pred_taken,
                               target:     alloc_target,
                               value:      32'd0,
                               jumppc:     32'd0};
        end
        // RS is written last so it wins a same-tag collision with the SLB.
        if (slb_hit) entries[slb_wb_tag].value <= slb_wb_value;
        if (rs_hit) begin
            entries[rs_wb_tag].value <= rs_wb_value;
            if (rs_wb_jumppc_valid) entries[rs_wb_tag].jumppc <= rs_wb_jumppc;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (default build, commit one cycle after the
// head becomes ready).
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, rdy;
    logic                   alloc_valid, alloc_ready;
    logic [3:0]             alloc_tag;
    logic [INST_TYPE_W-1:0] alloc_type;
    logic [4:0]             alloc_rd;
    logic [31:0]            alloc_pc, alloc_target;
    logic                   alloc_pred_taken;
    logic                   rs_wb_valid, rs_wb_jumppc_valid;
    logic [3:0]             rs_wb_tag;
    logic [31:0]            rs_wb_value, rs_wb_jumppc;
    logic                   slb_wb_valid;
    logic [3:0]             slb_wb_tag;
    logic [31:0]            slb_wb_value;
    logic                   commit_valid, store_commit, clear_flag;
    logic [3:0]             commit_tag;
    logic [4:0]             commit_rd;
    logic [31:0]            commit_value, redirect_pc;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_type(alloc_type), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_pred_taken(alloc_pred_taken), .alloc_target(alloc_target),
        .rs_wb_valid(rs_wb_valid), .rs_wb_tag(rs_wb_tag), .rs_wb_value(rs_wb_value),
        .rs_wb_jumppc_valid(rs_wb_jumppc_valid), .rs_wb_jumppc(rs_wb_jumppc),
        .slb_wb_valid(slb_wb_valid), .slb_wb_tag(slb_wb_tag), .slb_wb_value(slb_wb_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_value(commit_value), .store_commit(store_commit),
        .clear_flag(clear_flag), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input inst_type_e t, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pt, input logic [31:0] tgt);
        alloc_valid      = 1'b1;
        alloc_type       = t;
        alloc_rd         = rd;
        alloc_pc         = pc;
        alloc_pred_taken = pt;
        alloc_target     = tgt;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic rs_wb(input logic [3:0] tag, input logic [31:0] value,
                         input logic jv, input logic [31:0] jpc);
        rs_wb_valid        = 1'b1;
        rs_wb_tag          = tag;
        rs_wb_value        = value;
        rs_wb_jumppc_valid = jv;
        rs_wb_jumppc       = jpc;
        tick();
        rs_wb_valid        = 1'b0;
        rs_wb_jumppc_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1;
        alloc_valid = 1'b0; alloc_type = '0; alloc_rd = '0; alloc_pc = '0;
        alloc_pred_taken = 1'b0; alloc_target = '0;
        rs_wb_valid = 1'b0; rs_wb_tag = '0; rs_wb_value = '0;
        rs_wb_jumppc_valid = 1'b0; rs_wb_jumppc = '0;
        slb_wb_valid = 1'b0; slb_wb_tag = '0; slb_wb_value = '0;

        // Reset state
        tick(); tick();
        check("rst_alloc_ready", 32'(alloc_ready), 32'd0);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_clear_flag", 32'(clear_flag), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("post_rst_alloc_tag", 32'(alloc_tag), 32'd0);

        // Fill all 16 entries, then a 17th must be refused
        for (int i = 0; i < 16; i++) begin
            check("fill_tag", 32'(alloc_tag), 32'(i));
            alloc(INST_ALU, 5'd1, 32'h0, 1'b0, 32'h0);
        end
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        alloc(INST_ALU, 5'd1, 32'h0, 1'b0, 32'h0);
        check("reject17_alloc_ready", 32'(alloc_ready), 32'd0);
        check("reject17_alloc_tag", 32'(alloc_tag), 32'd0);
        check("full_no_commit", 32'(commit_valid), 32'd0);

        // Out-of-order writeback, in-order commit
        do_reset();
        alloc(INST_ALU, 5'd3, 32'h0, 1'b0, 32'h0);
        alloc(INST_ALU, 5'd4, 32'h4, 1'b0, 32'h0);
        rs_wb(4'd1, 32'd7, 1'b0, 32'h0);
        rs_wb(4'd0, 32'd5, 1'b0, 32'h0);
        check("ooo_wait", 32'(commit_valid), 32'd0);
        tick();
        check("ooo_c0_valid", 32'(commit_valid), 32'd1);
        check("ooo_c0_tag", 32'(commit_tag), 32'd0);
        check("ooo_c0_value", commit_value, 32'd5);
        check("ooo_c0_rd", 32'(commit_rd), 32'd3);
        tick();
        check("ooo_c1_valid", 32'(commit_valid), 32'd1);
        check("ooo_c1_tag", 32'(commit_tag), 32'd1);
        check("ooo_c1_value", commit_value, 32'd7);
        check("ooo_c1_rd", 32'(commit_rd), 32'd4);
        tick();
        check("ooo_done", 32'(commit_valid), 32'd0);
        check("ooo_tail", 32'(alloc_tag), 32'd2);

        // BEQ predicted not-taken but taken: flush and redirect
        do_reset();
        alloc(INST_BEQ, 5'd9, 32'h100, 1'b0, 32'h140);
        alloc(INST_ALU, 5'd2, 32'h104, 1'b0, 32'h0);
        rs_wb(4'd0, 32'd1, 1'b0, 32'h0);
        check("beq_wait", 32'(commit_valid), 32'd0);
        tick();
        check("beq_commit", 32'(commit_valid), 32'd1);
        check("beq_clear", 32'(clear_flag), 32'd1);
        check("beq_redirect", redirect_pc, 32'h140);
        check("beq_rd_zero", 32'(commit_rd), 32'd0);
        check("beq_clear_alloc_ready", 32'(alloc_ready), 32'd0);
        tick();
        check("beq_clear_pulse", 32'(clear_flag), 32'd0);
        check("beq_after_commit", 32'(commit_valid), 32'd0);
        check("beq_flushed_tail", 32'(alloc_tag), 32'd0);
        check("beq_flushed_ready", 32'(alloc_ready), 32'd1);

        // JALR with a wrong target, then with the predicted target
        alloc(INST_JALR, 5'd1, 32'h80, 1'b0, 32'h200);
        rs_wb(4'd0, 32'h84, 1'b1, 32'h208);
        tick();
        check("jalr_bad_commit", 32'(commit_valid), 32'd1);
        check("jalr_bad_clear", 32'(clear_flag), 32'd1);
        check("jalr_bad_redirect", redirect_pc, 32'h208);
        check("jalr_bad_rd", 32'(commit_rd), 32'd1);
        check("jalr_bad_value", commit_value, 32'h84);
        tick();
        alloc(INST_JALR, 5'd1, 32'h80, 1'b0, 32'h200);
        rs_wb(4'd0, 32'h84, 1'b1, 32'h200);
        tick();
        check("jalr_ok_commit", 32'(commit_valid), 32'd1);
        check("jalr_ok_clear", 32'(clear_flag), 32'd0);
        tick();
        check("jalr_ok_no_flush", 32'(alloc_tag), 32'd1);

        // Correctly predicted BNE, SLB store, RS-over-SLB collision
        alloc(INST_BNE, 5'd6, 32'h300, 1'b1, 32'h380);
        rs_wb(4'd1, 32'd1, 1'b0, 32'h0);
        tick();
        check("bne_commit", 32'(commit_valid), 32'd1);
        check("bne_no_clear", 32'(clear_flag), 32'd0);
        alloc(INST_SW, 5'd5, 32'h400, 1'b0, 32'h0);
        slb_wb_valid = 1'b1; slb_wb_tag = 4'd2; slb_wb_value = 32'hdead;
        tick();
        slb_wb_valid = 1'b0;
        tick();
        check("sw_commit", 32'(commit_valid), 32'd1);
        check("sw_store_commit", 32'(store_commit), 32'd1);
        check("sw_rd_zero", 32'(commit_rd), 32'd0);
        alloc(INST_ALU, 5'd8, 32'h404, 1'b0, 32'h0);
        check("sw_store_pulse", 32'(store_commit), 32'd0);
        slb_wb_valid = 1'b1; slb_wb_tag = 4'd3; slb_wb_value = 32'h22;
        rs_wb(4'd3, 32'h11, 1'b0, 32'h0);
        slb_wb_valid = 1'b0;
        tick();
        check("rs_wins_tag", 32'(commit_tag), 32'd3);
        check("rs_wins_value", commit_value, 32'h11);

        // Wrap-around: 15 entries, retire 3, allocate 4 across the 15->0 boundary
        do_reset();
        for (int i = 0; i < 15; i++) alloc(INST_ALU, 5'(i), 32'(4 * i), 1'b0, 32'h0);
        rs_wb(4'd0, 32'h50, 1'b0, 32'h0);
        check("wrap_c_none", 32'(commit_valid), 32'd0);
        rs_wb(4'd1, 32'h51, 1'b0, 32'h0);
        check("wrap_c0", 32'(commit_tag), 32'd0);
        rs_wb(4'd2, 32'h52, 1'b0, 32'h0);
        check("wrap_c1", 32'(commit_tag), 32'd1);
        tick();
        check("wrap_c2", 32'(commit_tag), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("wrap_alloc_tag", 32'(alloc_tag), 32'((15 + i) % 16));
            alloc(INST_ALU, 5'd1, 32'h0, 1'b0, 32'h0);
        end
        check("wrap_full", 32'(alloc_ready), 32'd0);
        for (int k = 15; k >= 0; k--) begin
            rs_wb(4'((k + 3) % 16), 32'h100 + 32'((k + 3) % 16), 1'b0, 32'h0);
        end
        check("wrap_wait", 32'(commit_valid), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("wrap_seq_valid", 32'(commit_valid), 32'd1);
            check("wrap_seq_tag", 32'(commit_tag), 32'((k + 3) % 16));
            check("wrap_seq_value", commit_value, 32'h100 + 32'((k + 3) % 16));
        end
        tick();
        check("wrap_drained", 32'(commit_valid), 32'd0);
        check("wrap_ready_again", 32'(alloc_ready), 32'd1);

        // Global stall with a ready head
        alloc(INST_ALU, 5'd7, 32'h0, 1'b0, 32'h0);
        rs_wb(4'd3, 32'h33, 1'b0, 32'h0);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_commit", 32'(commit_valid), 32'd0);
            check("stall_alloc_ready", 32'(alloc_ready), 32'd0);
        end
        rdy = 1'b1;
        tick();
        check("stall_release_commit", 32'(commit_valid), 32'd1);
        check("stall_release_tag", 32'(commit_tag), 32'd3);
        check("stall_release_value", commit_value, 32'h33);
        tick();
        check("stall_single", 32'(commit_valid), 32'd0);

        // Reset in the middle of a fill discards everything
        alloc(INST_ALU, 5'd1, 32'h0, 1'b0, 32'h0);
        alloc(INST_ALU, 5'd2, 32'h0, 1'b0, 32'h0);
        alloc(INST_ALU, 5'd3, 32'h0, 1'b0, 32'h0);
        rs_wb(4'd4, 32'h44, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        check("midrst_no_commit", 32'(commit_valid), 32'd0);
        check("midrst_alloc_ready", 32'(alloc_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_tail", 32'(alloc_tag), 32'd0);
        check("midrst_ready", 32'(alloc_ready), 32'd1);
        alloc(INST_ALU, 5'd1, 32'h0, 1'b0, 32'h0);
        tick();
        check("midrst_stale_ready", 32'(commit_valid), 32'd0);
        tick();
        check("midrst_quiet", 32'(commit_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
